// File: rtl/dsram_like_slave.sv
// dsram_like_slave: responder for the CPU's SRAM-like data port.
// Accepts req/addr_ok address phases, performs reads and byte-masked writes
// into a word-organised memory at accept time, and answers every accepted
// request in order with a one-cycle data_ok pulse after LAT extra cycles.
// Optional build macro: DSRAM_RAND_STALL_EN adds an LFSR that randomly
// withholds addr_ok (about one cycle in four) to stress requesters.
module dsram_like_slave #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2,
    parameter int LAT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int WORDS = 1 << ADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    localparam logic [3:0]       LAT_CNT  = 4'(LAT);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [31:0]       mem [WORDS];

    logic [DEPTH-1:0]  q_valid;
    logic [DEPTH-1:0]  q_read;
    logic [31:0]       q_data [DEPTH];
    logic [3:0]        q_cnt  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic [ADDR_W-1:0] idx;
    logic              head_ready;
    logic              room;
    logic              stall;
    logic              accept;

    // Byte offset, transfer size and address bits above the memory are
    // deliberately ignored; higher addresses alias onto the same words.
    logic              unused_bits;
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    assign idx = addr[ADDR_W+1:2];

    // Head of the response queue is due once its wait counter has run out.
    assign head_ready = q_valid[rd_ptr] && (q_cnt[rd_ptr] == 4'd0);
    assign data_ok    = !reset && head_ready;
    assign rdata      = (data_ok && q_read[rd_ptr]) ? q_data[rd_ptr] : 32'h0;

    // A full queue can still take a request in the cycle its head retires.
    assign room    = (occ != OCC_FULL) || data_ok;
    assign addr_ok = !reset && room && !stall;
    assign accept  = req && addr_ok;

`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, free-running out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b11);
`else
    assign stall = 1'b0;
`endif

    // Byte-masked write at accept; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Response queue: count down waits, retire the head, append new requests.
    // Read data is captured from mem before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_valid[i] && (q_cnt[i] != 4'd0)) begin
                    q_cnt[i] <= q_cnt[i] - 4'd1;
                end
            end

            if (data_ok) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            // When full, wr_ptr equals rd_ptr, so the push overrides the pop
            // on the shared slot.
            if (accept) begin
                q_valid[wr_ptr] <= 1'b1;
                q_read[wr_ptr]  <= !wr;
                q_data[wr_ptr]  <= wr ? 32'h0 : mem[idx];
                q_cnt[wr_ptr]   <= LAT_CNT;
                wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end

            case ({accept, data_ok})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsram_like_slave.sv
// Testbench for dsram_like_slave: three instances (LAT 0, 2, 3; DEPTH 2)
// exercised in turn with directed and random traffic and an in-order
// scoreboard of expected rdata values.
module tb_dsram_like_slave;

    localparam int NDUT = 3;

    logic        clk;
    logic        reset;
    logic        req     [NDUT];
    logic        wr      [NDUT];
    logic [1:0]  size    [NDUT];
    logic [31:0] addr    [NDUT];
    logic [3:0]  wstrb   [NDUT];
    logic [31:0] wdata   [NDUT];
    logic        addr_ok [NDUT];
    logic        data_ok [NDUT];
    logic [31:0] rdata   [NDUT];

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];

    dsram_like_slave #(.ADDR_W(10), .DEPTH(2), .LAT(0)) dut_l0 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .addr(addr[0]), .wstrb(wstrb[0]), .wdata(wdata[0]),
        .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0])
    );

    dsram_like_slave #(.ADDR_W(10), .DEPTH(2), .LAT(2)) dut_l2 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .addr(addr[1]), .wstrb(wstrb[1]), .wdata(wdata[1]),
        .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1])
    );

    dsram_like_slave #(.ADDR_W(10), .DEPTH(2), .LAT(3)) dut_l3 (
        .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .size(size[2]),
        .addr(addr[2]), .wstrb(wstrb[2]), .wdata(wdata[2]),
        .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DSRAM_RAND_STALL_EN
    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (reset) lfsr_m <= 16'hACE1;
        else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
    function automatic bit stall_m();
        return lfsr_m[1:0] == 2'b11;
    endfunction
`else
    function automatic bit stall_m();
        return 1'b0;
    endfunction
`endif

    task automatic drive(input int d, input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [3:0] st, input logic [31:0] dat);
        req[d]   = r;
        wr[d]    = w;
        size[d]  = s;
        addr[d]  = a;
        wstrb[d] = st;
        wdata[d] = dat;
    endtask

    task automatic idle_all();
        for (int d = 0; d < NDUT; d++) drive(d, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
    endtask

    // Single request on an idle DUT: waits (bounded) for accept, then for its
    // data_ok. Returns what was observed; callers judge it.
    task automatic xfer(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] dat,
                        output logic [31:0] rd, output int lat, output bit ok);
        bit acc = 1'b0;
        ok  = 1'b0;
        lat = -1;
        rd  = 'x;
        drive(d, 1'b1, w, s, a, st, dat);
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = addr_ok[d];
            @(posedge clk); #1;
        end
        drive(d, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        if (!acc) return;
        for (int n = 1; n <= 20 && !ok; n++) begin
            @(negedge clk);
            if (data_ok[d]) begin
                rd  = rdata[d];
                lat = n;
                ok  = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (addr_ok[d] !== 1'b0 || data_ok[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: addr_ok=%b data_ok=%b rdata=%h, expected 0 0 00000000",
                         d, addr_ok[d], data_ok[d], rdata[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (addr_ok[d] !== 1'b1 || data_ok[d] !== 1'b0) begin
                errors++;
                $display("FAIL after_reset dut%0d: addr_ok=%b data_ok=%b, expected 1 0",
                         d, addr_ok[d], data_ok[d]);
            end
        end
        @(posedge clk); #1;
    endtask

    // LAT=0: write then read back-to-back, responses one cycle after accept.
    task automatic test_write_read();
        logic [3:0]  exp_dok = 4'b0110;
        logic [31:0] exp;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            if (k == 0)      drive(0, 1'b1, 1'b1, 2'd2, 32'h1000_0010, 4'hF, 32'hDEADBEEF);
            else if (k == 1) drive(0, 1'b1, 1'b0, 2'd2, 32'h1000_0010, 4'h0, 32'h0);
            else             drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            checks++;
            if (data_ok[0] !== exp_dok[k]) begin
                errors++;
                $display("FAIL t1_data_ok k=%0d: got %b, expected %b", k, data_ok[0], exp_dok[k]);
            end
            if (data_ok[0] === 1'b1) begin
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                if (rdata[0] !== exp) begin
                    errors++;
                    $display("FAIL t1_rdata k=%0d: got %h, expected %h", k, rdata[0], exp);
                end
            end
            if (req[0]) begin
                checks++;
                if (addr_ok[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL t1_addr_ok k=%0d: got %b, expected 1", k, addr_ok[0]);
                end
                if (addr_ok[0] === 1'b1) exp_q.push_back(k == 0 ? 32'h0 : 32'hDEADBEEF);
            end
            @(posedge clk); #1;
        end
    endtask

    // Byte-lane merge, address aliasing and ignored low/size bits.
    task automatic test_byte_strobe();
        logic [31:0] rd;
        int          lat;
        bit          ok;
        logic [31:0] a_list [5] = '{32'h1000_0010, 32'h1000_0010, 32'h1000_0010,
                                    32'h1000_1010, 32'h1000_0013};
        logic        w_list [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0]  s_list [5] = '{4'hF, 4'b0100, 4'h0, 4'h0, 4'h0};
        logic [31:0] d_list [5] = '{32'hDEADBEEF, 32'h00AB0000, 32'h0, 32'h0, 32'h0};
        logic [1:0]  z_list [5] = '{2'd2, 2'd0, 2'd2, 2'd3, 2'd1};
        logic [31:0] e_list [5] = '{32'h0, 32'h0, 32'hDEABBEEF, 32'hDEABBEEF, 32'hDEABBEEF};
        for (int i = 0; i < 5; i++) begin
            exp_q.delete();
            exp_q.push_back(e_list[i]);
            xfer(0, w_list[i], z_list[i], a_list[i], s_list[i], d_list[i], rd, lat, ok);
            checks++;
            if (!ok || lat != 1 || rd !== exp_q[0]) begin
                errors++;
                $display("FAIL t2_xfer%0d: ok=%0d latency=%0d rdata=%h, expected ok=1 latency=1 rdata=%h",
                         i, ok, lat, rd, exp_q[0]);
            end
        end
        exp_q.delete();
    endtask

    // LAT=2: two back-to-back reads answer at T+3 and T+4 with no gap.
    task automatic test_latency();
        logic [31:0] rd;
        int          lat;
        bit          ok;
        logic [5:0]  exp_dok = 6'b011000;
        logic [31:0] exp;
        xfer(1, 1'b1, 2'd2, 32'h40, 4'hF, 32'hA5A5_0001, rd, lat, ok);
        checks++;
        if (!ok || lat != 3) begin
            errors++;
            $display("FAIL t3_prewrite: ok=%0d latency=%0d, expected ok=1 latency=3", ok, lat);
        end
        xfer(1, 1'b1, 2'd2, 32'h44, 4'hF, 32'h5A5A_0002, rd, lat, ok);
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            if (k < 2) drive(1, 1'b1, 1'b0, 2'd2, (k == 0) ? 32'h40 : 32'h44, 4'h0, 32'h0);
            else       drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            checks++;
            if (data_ok[1] !== exp_dok[k]) begin
                errors++;
                $display("FAIL t3_data_ok k=%0d: got %b, expected %b", k, data_ok[1], exp_dok[k]);
            end
            if (data_ok[1] === 1'b1) begin
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                if (rdata[1] !== exp) begin
                    errors++;
                    $display("FAIL t3_rdata k=%0d: got %h, expected %h", k, rdata[1], exp);
                end
            end
            if (req[1]) begin
                checks++;
                if (addr_ok[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL t3_addr_ok k=%0d: got %b, expected 1", k, addr_ok[1]);
                end
                if (addr_ok[1] === 1'b1) exp_q.push_back((k == 0) ? 32'hA5A5_0001 : 32'h5A5A_0002);
            end
            @(posedge clk); #1;
        end
    endtask

    // DEPTH=2, LAT=3 with req held: backpressure and push+pop when full.
    task automatic test_back_to_back();
        logic [10:0] exp_aok = 11'h733;
        logic [10:0] exp_dok = 11'h330;
        logic        t_wr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_adr [4] = '{32'h200, 32'h200, 32'h204, 32'h204};
        logic [31:0] t_dat [4] = '{32'h1111_2222, 32'h0, 32'h3333_4444, 32'h0};
        logic [31:0] t_exp [4] = '{32'h0, 32'h1111_2222, 32'h0, 32'h3333_4444};
        int          n_acc = 0;
        logic [31:0] exp;
        exp_q.delete();
        for (int k = 0; k < 11; k++) begin
            if (k <= 6 && n_acc < 4) drive(2, 1'b1, t_wr[n_acc], 2'd2, t_adr[n_acc], 4'hF, t_dat[n_acc]);
            else                     drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
            @(negedge clk);
            checks++;
            if (addr_ok[2] !== exp_aok[k] || data_ok[2] !== exp_dok[k]) begin
                errors++;
                $display("FAIL t4_handshake k=%0d: addr_ok=%b data_ok=%b, expected %b %b",
                         k, addr_ok[2], data_ok[2], exp_aok[k], exp_dok[k]);
            end
            if (data_ok[2] === 1'b1) begin
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                if (rdata[2] !== exp) begin
                    errors++;
                    $display("FAIL t4_rdata k=%0d: got %h, expected %h", k, rdata[2], exp);
                end
            end
            if (req[2] && addr_ok[2] === 1'b1) begin
                exp_q.push_back(t_exp[n_acc]);
                n_acc++;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n_acc != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL t4_totals: accepts=%0d pending=%0d, expected 4 0", n_acc, exp_q.size());
        end
    endtask

    // Reset with two reads outstanding: they are dropped, memory survives.
    task automatic test_reset_mid();
        logic [31:0] rd;
        int          lat;
        bit          ok;
        int          n_acc = 0;
        int          n_dok = 0;
        xfer(2, 1'b1, 2'd2, 32'h208, 4'hF, 32'hCAFE_F00D, rd, lat, ok);
        for (int c = 0; c < 20 && n_acc < 2; c++) begin
            drive(2, 1'b1, 1'b0, 2'd2, 32'h208, 4'h0, 32'h0);
            @(negedge clk);
            if (addr_ok[2] === 1'b1) n_acc++;
            @(posedge clk); #1;
        end
        drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        checks++;
        if (n_acc != 2) begin
            errors++;
            $display("FAIL t5_issue: accepts=%0d, expected 2", n_acc);
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (addr_ok[2] !== 1'b0 || data_ok[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL t5_in_reset: addr_ok=%b data_ok=%b rdata=%h, expected 0 0 00000000",
                     addr_ok[2], data_ok[2], rdata[2]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (addr_ok[2] !== 1'b1) begin
            errors++;
            $display("FAIL t5_addr_ok_after: got %b, expected 1", addr_ok[2]);
        end
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (data_ok[2] !== 1'b0) n_dok++;
            @(posedge clk); #1;
        end
        checks++;
        if (n_dok != 0) begin
            errors++;
            $display("FAIL t5_dropped: data_ok pulses=%0d, expected 0", n_dok);
        end
        xfer(2, 1'b0, 2'd2, 32'h208, 4'h0, 32'h0, rd, lat, ok);
        checks++;
        if (!ok || lat != 4 || rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL t5_readback: ok=%0d latency=%0d rdata=%h, expected 1 4 cafef00d", ok, lat, rd);
        end
    endtask

    // Req held for 64 cycles with random traffic on the LAT=3 instance.
    task automatic test_random();
        logic [31:0] mem_m [int];
        logic [31:0] rd, a, dat, exp;
        logic [3:0]  st;
        logic        w, exp_ok;
        int          lat, idx, occ_m;
        bit          ok;
        int          n_acc = 0;
        int          n_dok = 0;
        for (int i = 0; i < 4; i++) begin
            dat = $urandom;
            xfer(2, 1'b1, 2'd2, 32'h300 + 32'(4 * i), 4'hF, dat, rd, lat, ok);
            mem_m[32'hC0 + i] = dat;
        end
        exp_q.delete();
        for (int c = 0; c < 64; c++) begin
            w   = 1'($urandom_range(0, 1));
            idx = 32'hC0 + $urandom_range(0, 3);
            a   = ($urandom & 32'hFFFF_F003) | 32'(idx << 2);
            st  = 4'($urandom);
            dat = $urandom;
            drive(2, 1'b1, w, 2'($urandom), a, st, dat);
            @(negedge clk);
            occ_m  = exp_q.size();
            exp_ok = !stall_m() && (occ_m < 2 || data_ok[2] === 1'b1);
            checks++;
            if (addr_ok[2] !== exp_ok) begin
                errors++;
                $display("FAIL t6_addr_ok c=%0d: got %b, expected %b", c, addr_ok[2], exp_ok);
            end
            if (data_ok[2] === 1'b1) begin
                n_dok++;
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                if (rdata[2] !== exp) begin
                    errors++;
                    $display("FAIL t6_rdata c=%0d: got %h, expected %h", c, rdata[2], exp);
                end
            end
            if (addr_ok[2] === 1'b1) begin
                n_acc++;
                if (w) begin
                    exp_q.push_back(32'h0);
                    for (int b = 0; b < 4; b++)
                        if (st[b]) mem_m[idx][8*b +: 8] = dat[8*b +: 8];
                end else begin
                    exp_q.push_back(mem_m[idx]);
                end
            end
            @(posedge clk); #1;
        end
        drive(2, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (data_ok[2] === 1'b1) begin
                n_dok++;
                checks++;
                exp = exp_q.pop_front();
                if (rdata[2] !== exp) begin
                    errors++;
                    $display("FAIL t6_drain_rdata: got %h, expected %h", rdata[2], exp);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (n_dok != n_acc || exp_q.size() != 0 || n_acc == 0) begin
            errors++;
            $display("FAIL t6_counts: data_ok=%0d accepts=%0d pending=%0d, expected equal counts and 0 pending",
                     n_dok, n_acc, exp_q.size());
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
`ifndef DSRAM_RAND_STALL_EN
        test_write_read();
`endif
        test_byte_strobe();
`ifndef DSRAM_RAND_STALL_EN
        test_latency();
        test_back_to_back();
`endif
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsram_like_slave.md
Name: dsram_like_slave

Overview:
Responder end of the CPU's SRAM-like data interface. It accepts req/addr_ok address-phase handshakes from the MEM/EXE pipeline and holds a word-organised memory. It answers every accepted request, in order, with a one-cycle data_ok pulse carrying rdata, after a configurable latency. It serves as the data-RAM model in CPU-level simulation and as the on-chip scratch RAM behind the data port.

Parameters:
ADDR_W, 10, word-index width; memory depth is 2**ADDR_W 32-bit words.
DEPTH, 2, maximum number of outstanding accepted-but-unanswered requests (>=1).
LAT, 0, extra wait cycles before data_ok (0..15).

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  1  request valid (address phase)
wr  input  1  1 = write, 0 = read
size  input  2  0 = byte, 1 = half, 2 = word; informational only, wstrb governs the write
addr  input  32  byte address
wstrb  input  4  byte write enables, used only when wr=1
wdata  input  32  write data
addr_ok  output  1  request accepted this cycle when req && addr_ok
data_ok  output  1  one-cycle response pulse for the oldest outstanding request
rdata  output  32  read data, valid while data_ok is high

Behaviour:
- Clock clk; reset synchronous, active-high; all state updates on posedge clk.
- Memory index is addr[ADDR_W+1:2]. addr[1:0] and the upper address bits are ignored, so higher addresses alias.
- Memory is not reset. Reads of never-written words return X.
- Accept = req && addr_ok.
- On a write accept: in the same clock edge, byte lane i is written with wdata[8i+7:8i] for each i where wstrb[i]=1.
- On a read accept: the addressed word is sampled in the same cycle, before any write of that edge, and stored in the response queue.
- Because writes and reads take effect at accept, a read accepted after a write always sees that write.
- Response queue: circular FIFO of DEPTH entries; pointers wrap modulo DEPTH. Each entry holds {is_read, data, cnt[3:0]}.
  - On push, cnt is loaded with LAT.
  - Every cycle, each valid entry with cnt != 0 decrements by 1; cnt saturates at 0.
- data_ok = head entry valid && head cnt == 0. data_ok pops the head in that cycle.
- rdata = head data when data_ok && is_read; otherwise 32'h0.
- Latency: a request accepted in cycle T gets data_ok in cycle T+1+LAT, or later if older entries are still waiting. Throughput is one response per cycle.
- Ordering: strictly in order; each accepted request gets exactly one data_ok. Writes get a data_ok with rdata 0.
- addr_ok = !reset && (occupancy < DEPTH || data_ok). A push and a pop in the same cycle are allowed when full; occupancy is then unchanged.
- addr_ok does not depend combinationally on req.
- Occupancy counter is 0..DEPTH. Push and pop in the same cycle leave it unchanged. Empty: data_ok=0. Full with no pop: addr_ok=0.
- There is no cancel input. After a pipeline flush the requester must still absorb all pending data_ok pulses.
- Reset, including mid-operation: queue emptied, pointers and occupancy set to 0, outstanding responses discarded. During reset data_ok=0, rdata=0, addr_ok=0.
  - addr_ok=1 in the first cycle after reset deasserts.
  - Memory keeps all writes completed before reset.
- size values other than 0..2 have no effect on behaviour.

Optional Feature:
Macro DSRAM_RAND_STALL_EN.
- Defined: adds a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1.
  - Reset value 16'hACE1; advances every cycle when not in reset.
  - addr_ok is additionally forced to 0 whenever lfsr[1:0]==2'b11, giving about 25% random address-phase stall to stress requester handshakes.
  - data_ok timing is unaffected.
- Undefined: no LFSR and no gating; addr_ok follows the base rule exactly.

Test Plan:
1. LAT=0: write addr 0x1000_0010, wstrb 4'hF, wdata 0xDEADBEEF, accepted at T -> data_ok=1 at T+1 with rdata 0. Read of the same address accepted at T+1 -> data_ok at T+2, rdata 0xDEADBEEF.
2. Over 0xDEADBEEF, write wstrb 4'b0100, wdata 0x00AB0000, then read the same word -> rdata 0xDEABBEEF. A read at addr+0x1000*(2**ADDR_W)/1024 (alias) returns the same value.
3. LAT=2: reads accepted at T and T+1 -> data_ok at T+3 and T+4, with rdata in request order and no gap.
4. DEPTH=2, LAT=3, req held high:
   - accepts at T and T+1; addr_ok=0 at T+2 and T+3;
   - at T+4, data_ok and addr_ok both 1, third request accepted, occupancy stays 2;
   - second data_ok at T+5.
5. Two reads outstanding, reset asserted for one cycle -> data_ok never pulses for them; addr_ok=1 the cycle after reset. A read of a previously written word returns the old data.
6. With DSRAM_RAND_STALL_EN, req held 64 cycles with random wr/addr -> addr_ok=0 exactly on cycles where lfsr[1:0]==3. The number of data_ok pulses equals the number of accepts, and a scoreboard matches all rdata.
